// File: rtl/multibyte_add_sequencer_if.sv
// multibyte_add_sequencer_if: request/result handshake bundle for the multi-byte add sequencer
interface multibyte_add_sequencer_if #(parameter int NBYTES = 4);
    localparam int W = 8 * NBYTES;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow
    );
    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow
    );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer: multi-precision add/subtract, one byte per clock through a single 8-bit adder
module eight_bit_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out
);
    assign {carry_out, sum} = {1'b0, x} + {1'b0, y} + {8'd0, carry_in};
endmodule

module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    multibyte_add_sequencer_if.slave  bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic          cy_q, cy_d;
    logic          co_q, co_d;
    logic          ov_q, ov_d;
    logic [7:0]    x, y, sum;
    logic          add_co;
    logic          last;

    assign x    = a_q[{idx_q, 3'b000} +: 8];
    assign y    = b_q[{idx_q, 3'b000} +: 8];
    assign last = idx_q == IW'(NBYTES - 1);

    eight_bit_adder u_add (
        .x         (x),
        .y         (y),
        .carry_in  (cy_q),
        .sum       (sum),
        .carry_out (add_co)
    );

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = result_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;

    // Subtraction is A + ~B + ~borrow, so operands are conditioned once at capture time
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cy_d     = cy_q;
        co_d     = co_q;
        ov_d     = ov_q;
        if (state_q == IDLE && bus.in_valid && bus.in_ready) begin
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            cy_d    = bus.carry_in ^ bus.sub;
            idx_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            result_d[{idx_q, 3'b000} +: 8] = sum;
            cy_d  = add_co;
            idx_d = last ? '0 : idx_q + 1'b1;
            if (last) begin
                co_d    = add_co;
                ov_d    = (x[7] == y[7]) && (sum[7] != x[7]);
                state_d = DONE;
            end
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cy_q     <= 1'b0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cy_q     <= cy_d;
            co_q     <= co_d;
            ov_q     <= ov_d;
        end
    end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// tb_multibyte_add_sequencer: directed self-checking bench for multibyte_add_sequencer (NBYTES=4)
module tb_multibyte_add_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multibyte_add_sequencer_if #(.NBYTES(4)) bus ();

    multibyte_add_sequencer #(.NBYTES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for its result; leaves the block idle afterwards
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb,
                         output int lat, output logic [31:0] r, output logic co, output logic ov);
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.carry_in = ci;
        bus.sub = sb;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        r  = bus.result;
        co = bus.carry_out;
        ov = bus.overflow;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b exp=0", bus.in_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", bus.result); end
        checks++;
        if (bus.carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry_out got=%b exp=0", bus.carry_out); end
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_arith();
        logic [31:0] av [7];
        logic [31:0] bv [7];
        logic        cv [7];
        logic        sv [7];
        logic [31:0] er [7];
        logic        ec [7];
        logic        eo [7];
        int          lat;
        logic [31:0] r;
        logic        co, ov;
        av = '{32'd100, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd99, 32'd55, 32'd127, 32'h80000000};
        bv = '{32'd12, 32'd1, 32'd0, 32'd45, 32'd127, 32'd127, 32'd1};
        cv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        sv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        er = '{32'd112, 32'h00000000, 32'h80000000, 32'd145, 32'hFFFFFFB8, 32'hFFFFFFFF, 32'h7FFFFFFF};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL arith[%0d]_in_ready got=%b exp=1", i, bus.in_ready); end
            do_op(av[i], bv[i], cv[i], sv[i], lat, r, co, ov);
            checks++;
            if (lat !== 4) begin failures++; $display("FAIL arith[%0d]_latency got=%0d exp=4", i, lat); end
            checks++;
            if (r !== er[i]) begin failures++; $display("FAIL arith[%0d]_result got=%h exp=%h", i, r, er[i]); end
            checks++;
            if (co !== ec[i]) begin failures++; $display("FAIL arith[%0d]_carry_out got=%b exp=%b", i, co, ec[i]); end
            checks++;
            if (ov !== eo[i]) begin failures++; $display("FAIL arith[%0d]_overflow got=%b exp=%b", i, ov, eo[i]); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 32'd1000;
        bus.b = 32'd2000;
        bus.carry_in = 1'b0;
        bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.a = 32'd5;
        bus.b = 32'd6;
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
            checks++;
            if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, bus.out_valid); end
            checks++;
            if (bus.result !== 32'd3000) begin failures++; $display("FAIL bp_result[%0d] got=%h exp=%h", i, bus.result, 32'd3000); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept_in_ready got=%b exp=0", bus.in_ready); end
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL bp_second_latency got=%0d exp=4", lat); end
        checks++;
        if (bus.result !== 32'd11) begin failures++; $display("FAIL bp_second_result got=%h exp=%h", bus.result, 32'd11); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        logic        seen;
        int          lat;
        logic [31:0] r;
        logic        co, ov;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 32'h11111111;
        bus.b = 32'h22222222;
        bus.carry_in = 1'b0;
        bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.result !== 32'h0) begin failures++; $display("FAIL midrst_result got=%h exp=00000000", bus.result); end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL midrst_stale_out_valid got=%b exp=0", seen); end
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat, r, co, ov);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL midrst_after_latency got=%0d exp=4", lat); end
        checks++;
        if (r !== 32'h00000100) begin failures++; $display("FAIL midrst_after_result got=%h exp=00000100", r); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.carry_in = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
Sequences the existing combinational eight_bit_adder (ports x, y, carry_in, sum, carry_out) to add or subtract NBYTES-byte operands, one byte per clock, LSB byte first. The carry is chained through a register. Exactly one eight_bit_adder instance is used; no wide adder is inferred. Operands enter over a valid/ready handshake and results leave over a valid/ready handshake. Sits between a requester and downstream logic as a multi-precision arithmetic unit.

Parameters:
NBYTES, 4, operand width in bytes (≥1); datapath width W = 8*NBYTES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept request
a  input  W  operand A (unsigned / two's complement)
b  input  W  operand B
carry_in  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: A+B+carry_in; 1: A-B-carry_in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  sum/difference
carry_out  output  1  final adder carry (sub: 1 = no borrow)
overflow  output  1  signed overflow of W-bit operation

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE) && !reset; out_valid = (state==DONE).
- Reset (any state, including mid-RUN): state<=IDLE, idx<=0, result<=0, carry_out<=0, overflow<=0, carry register<=0. Any in-flight operation is discarded and never produces out_valid.
- IDLE: on edge with in_valid && in_ready:
  - capture a -> A_reg; b -> B_reg, or ~b if sub=1.
  - carry register <= carry_in, or ~carry_in if sub=1.
  - idx<=0; state<=RUN. Inputs are ignored otherwise.
- RUN, each edge:
  - adder gets x=A_reg[8*idx+:8], y=B_reg[8*idx+:8], carry_in=carry register.
  - result[8*idx+:8] <= sum; carry register <= adder carry_out; idx<=idx+1.
  - on the edge where idx==NBYTES-1: carry_out <= adder carry_out; overflow <= (x[7]==y[7]) && (sum[7]!=x[7]); state<=DONE.
- Latency: out_valid rises exactly NBYTES edges after the accept edge (NBYTES=1: one edge).
- Result bytes not yet computed hold their prior value during RUN. result is only meaningful while out_valid=1.
- DONE: result, carry_out and overflow stay stable while out_ready=0. On edge with out_ready=1: state<=IDLE.
- Throughput: one operation per NBYTES+2 cycles when out_ready is tied high. A new request cannot be accepted in the same cycle a result is consumed.
- in_valid while busy: in_ready=0, nothing is captured; the requester must hold its operands.
- Wrap-around: the result is modulo 2^W. The carry beyond bit W-1 appears only on carry_out.

Test Plan:
- NBYTES=4, a=100, b=12, carry_in=0, sub=0 -> out_valid exactly 4 edges after accept; result=112, carry_out=0, overflow=0.
- a=0xFFFFFFFF, b=1, carry_in=0, add -> result=0x00000000, carry_out=1, overflow=0 (carry ripples across all 4 bytes).
- a=0x7FFFFFFF, b=0, carry_in=1, add -> result=0x80000000, carry_out=0, overflow=1. Also a=99, b=45, carry_in=1 -> result=145, carry_out=0, overflow=0.
- sub=1, a=55, b=127, carry_in=0 -> result=0xFFFFFFB8, carry_out=0 (borrow), overflow=0. Then a=127, b=127, carry_in=1 -> result=0xFFFFFFFF, carry_out=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while in_valid=1 with new operands -> in_ready stays 0 and result is stable. On the out_ready=1 edge state goes to IDLE; the next edge accepts the new operands.
- Reset asserted for one cycle while idx==2 -> next cycle state IDLE, in_ready=1, out_valid=0, result=0, and no out_valid appears for the aborted operation.
